adc9826_spi_resp: RTL and testbench

- Responder (slave) end of the AD9826 3-wire serial config port; the counterpart of the adc9826_cfg master (sclk/sload/sdata).
- Oversamples sclk/sload/sdata on a single system clock and decodes 16-bit frames.
- Holds the 8 x 9-bit AD9826 register file and answers read frames on the shared sdata line.
- Used as a bench/loopback model and as a PL-side register shadow for bring-up without silicon.

---
 rtl/adc9826_pkg.sv | 22 ++
 rtl/adc9826_spi_sync.sv | 51 +++++
 rtl/adc9826_spi_resp.sv | 141 ++++++++++++++
 tb/tb_adc9826_spi_resp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc9826_pkg.sv
// AD9826 serial-port responder: shared constants, reset image and FSM states.
// Readback drive is built only with ADC9826_SPI_READBACK_EN defined.
package adc9826_pkg;

  localparam int ADC9826_NREGS      = 8;
  localparam int ADC9826_DW         = 9;
  localparam int ADC9826_AW         = 3;
  localparam int ADC9826_FRAME_BITS = 16;
  localparam int ADC9826_HDR_BITS   = 7;

  typedef logic [ADC9826_NREGS-1:0][ADC9826_DW-1:0] regfile_t;

  localparam regfile_t REG_DEFAULT = regfile_t'({63'd0, 9'h0C8});

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA
  } state_t;

endpackage

// File: rtl/adc9826_spi_sync.sv
// Pin synchronizers plus registered rise/fall detect for sclk and sload.
// Edge pulses and data appear SYNC_STAGES+1 clocks after the pin moves.
module adc9826_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_in,
  input  logic sload_in,
  input  logic sdata_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic sload_rise,
  output logic sload_fall,
  output logic sdata
);

  logic [SYNC_STAGES-1:0] sclk_m;
  logic [SYNC_STAGES-1:0] sload_m;
  logic [SYNC_STAGES-1:0] sdata_m;
  logic                   sclk_q;
  logic                   sload_q;

  // sload idles high, so its chain resets high to avoid a fake edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_m     <= '0;
      sload_m    <= '1;
      sdata_m    <= '0;
      sclk_q     <= 1'b0;
      sload_q    <= 1'b1;
      sclk_rise  <= 1'b0;
      sclk_fall  <= 1'b0;
      sload_rise <= 1'b0;
      sload_fall <= 1'b0;
      sdata      <= 1'b0;
    end else begin
      sclk_m     <= {sclk_m[SYNC_STAGES-2:0], sclk_in};
      sload_m    <= {sload_m[SYNC_STAGES-2:0], sload_in};
      sdata_m    <= {sdata_m[SYNC_STAGES-2:0], sdata_in};
      sclk_q     <= sclk_m[SYNC_STAGES-1];
      sload_q    <= sload_m[SYNC_STAGES-1];
      sclk_rise  <= sclk_m[SYNC_STAGES-1] & ~sclk_q;
      sclk_fall  <= ~sclk_m[SYNC_STAGES-1] & sclk_q;
      sload_rise <= sload_m[SYNC_STAGES-1] & ~sload_q;
      sload_fall <= ~sload_m[SYNC_STAGES-1] & sload_q;
      sdata      <= sdata_m[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/adc9826_spi_resp.sv
// AD9826 3-wire config port responder with 8 x 9-bit register file.
// Define ADC9826_SPI_READBACK_EN to drive read data on sdata_o/sdata_oe.
module adc9826_spi_resp
  import adc9826_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int SCLK_DIV_MIN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk_in,
  input  logic        sload_in,
  input  logic        sdata_in,
  output logic        sdata_o,
  output logic        sdata_oe,
  output logic [71:0] regs_o,
  output logic        wr_strobe_o,
  output logic [2:0]  wr_addr_o,
  output logic        frame_err_o
);

  logic [1:0] rst_ff;
  logic       rst_sn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_ff <= '0;
    else        rst_ff <= {rst_ff[0], 1'b1};
  end

  assign rst_sn = rst_ff[1];

  logic sclk_rise;
  logic sclk_fall;
  logic sload_rise;
  logic sload_fall;
  logic sdata_s;

  adc9826_spi_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_sn),
    .sclk_in   (sclk_in),
    .sload_in  (sload_in),
    .sdata_in  (sdata_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .sload_rise(sload_rise),
    .sload_fall(sload_fall),
    .sdata     (sdata_s)
  );

  state_t          state;
  logic [4:0]      cnt;
  logic [4:0]      cnt_n;
  logic [8:0]      sh;
  logic [8:0]      sh_n;
  logic [2:0]      addr;
  regfile_t        regs;
  logic            take;

  // a same-clock sclk rise is folded in before any end-of-frame decision
  always_comb begin
    take  = sclk_rise && (state != IDLE);
    cnt_n = cnt;
    sh_n  = sh;
    if (take) begin
      sh_n  = {sh[7:0], sdata_s};
      cnt_n = (cnt == 5'd17) ? 5'd17 : cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_sn) begin
    if (!rst_sn) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      addr        <= '0;
      regs        <= REG_DEFAULT;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      frame_err_o <= 1'b0;
    end else begin
      wr_strobe_o <= 1'b0;
      frame_err_o <= 1'b0;
      if (state == IDLE) begin
        if (sload_fall) begin
          state <= HDR;
          cnt   <= '0;
          sh    <= '0;
        end
      end else begin
        cnt <= cnt_n;
        sh  <= sh_n;
        if (sload_rise) begin
          state <= IDLE;
          if (cnt_n != 5'(ADC9826_FRAME_BITS)) begin
            frame_err_o <= 1'b1;
          end else if (state == WDATA) begin
            regs[addr]  <= sh_n;
            wr_strobe_o <= 1'b1;
            wr_addr_o   <= addr;
          end
        end else if (state == HDR && take &&
                     cnt_n == 5'(ADC9826_HDR_BITS)) begin
          addr  <= sh_n[5:3];
          state <= sh_n[6] ? RDATA : WDATA;
        end
      end
    end
  end

  assign regs_o = regs;

`ifdef ADC9826_SPI_READBACK_EN
  logic [3:0] rd_idx;

  // fall after rise 7 drives D8; from rise 15 on D0 is held
  assign rd_idx = (cnt >= 5'd15) ? 4'd0 : 4'(5'd15 - cnt);

  always_ff @(posedge clk or negedge rst_sn) begin
    if (!rst_sn) begin
      sdata_o  <= 1'b0;
      sdata_oe <= 1'b0;
    end else if (state != IDLE && sload_rise) begin
      sdata_o  <= 1'b0;
      sdata_oe <= 1'b0;
    end else if (state == RDATA && sclk_fall) begin
      sdata_o  <= regs[addr][rd_idx];
      sdata_oe <= 1'b1;
    end
  end
`else
  assign sdata_o  = 1'b0;
  assign sdata_oe = 1'b0;
`endif

  logic unused;
  assign unused = ^{sh[8], sclk_fall, SCLK_DIV_MIN[0]};

endmodule

// File: tb/tb_adc9826_spi_resp.sv
// Randomized scoreboard bench for adc9826_spi_resp.
// Honors ADC9826_SPI_READBACK_EN the same way as the RTL build.
module tb_adc9826_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk_in = 1'b0;
  logic        sload_in = 1'b1;
  logic        sdata_in = 1'b0;
  logic        sdata_o;
  logic        sdata_oe;
  logic [71:0] regs_o;
  logic        wr_strobe_o;
  logic [2:0]  wr_addr_o;
  logic        frame_err_o;

  adc9826_spi_resp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk_in    (sclk_in),
    .sload_in   (sload_in),
    .sdata_in   (sdata_in),
    .sdata_o    (sdata_o),
    .sdata_oe   (sdata_oe),
    .regs_o     (regs_o),
    .wr_strobe_o(wr_strobe_o),
    .wr_addr_o  (wr_addr_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  localparam int K_WR  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    int         addr;
    logic [8:0] data;
  } exp_t;

  exp_t       ev_q[$];
  logic [8:0] rd_q[$];
  logic [8:0] model [8];
  int         checks = 0;
  int         errors = 0;
  bit         tb_abort = 1'b0;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] model_flat();
    logic [71:0] f;
    for (int i = 0; i < 8; i++) f[i*9 +: 9] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 9'h000;
    model[0] = 9'h0C8;
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // write/error events
  initial forever begin
    @(negedge clk);
    if (wr_strobe_o || frame_err_o) begin
      if (ev_q.size() == 0) begin
        chk("unexpected_event", {wr_strobe_o, frame_err_o}, 0);
      end else begin
        exp_t e;
        e = ev_q.pop_front();
        chk("event_kind", wr_strobe_o ? K_WR : K_ERR, e.kind);
        if (e.kind == K_WR && wr_strobe_o) begin
          chk("wr_addr", wr_addr_o, e.addr);
          chk("wr_data", regs_o[e.addr*9 +: 9], e.data);
        end
      end
    end
  end

  // read data as seen by the master on sclk rises 8..16
  initial forever begin
    int         rcnt;
    bit         oe_seen;
    bit         early_oe;
    logic [8:0] word;
    @(negedge sload_in);
    rcnt = 0; oe_seen = 0; early_oe = 0; word = '0;
    forever begin
      @(posedge sclk_in or posedge sload_in);
      if (sload_in) break;
      rcnt++;
      if (rcnt <= 7 && sdata_oe) early_oe = 1;
      if (rcnt >= 8 && rcnt <= 16) word = {word[7:0], sdata_o};
      if (rcnt == 8 && sdata_oe) oe_seen = 1;
    end
    if (rcnt == 16 && !tb_abort) begin
      if (rd_q.size() > 0) begin
        logic [8:0] x;
        x = rd_q.pop_front();
        chk("rd_oe_window", {early_oe, oe_seen}, 2'b01);
        chk("rd_data", word, x);
      end else begin
        chk("oe_quiet", {early_oe, oe_seen}, 2'b00);
      end
    end
  end

  task automatic frame(input bit rw, input logic [2:0] a,
                       input logic [8:0] d, input int n);
    logic [15:0] w;
    logic [2:0]  dc;
    dc = 3'($urandom);
    w  = {rw, a, dc, d};
    if (n == 16) begin
      if (!rw) begin
        ev_q.push_back('{K_WR, int'(a), d});
        model[a] = d;
      end else begin
`ifdef ADC9826_SPI_READBACK_EN
        rd_q.push_back(model[a]);
`endif
      end
    end else begin
      ev_q.push_back('{K_ERR, 0, 9'h0});
    end
    sload_in = 1'b0;
    wclk(4);
    for (int i = 0; i < n; i++) begin
      sdata_in = (i < 16) ? w[15-i] : 1'($urandom);
      wclk(5);
      sclk_in = 1'b1;
      wclk(5);
      sclk_in = 1'b0;
    end
    wclk(5);
    sload_in = 1'b1;
    wclk(12);
    chk("oe_after_frame", sdata_oe, 1'b0);
    chk("regs_after_frame", regs_o, model_flat());
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_oe", {sdata_oe, sdata_o}, 2'b00);
    chk("rst_strobe", {wr_strobe_o, frame_err_o}, 2'b00);
    chk("rst_addr", wr_addr_o, 3'd0);
    chk("rst_regs", regs_o, model_flat());
    wclk(2);
    rst_n = 1'b1;
    wclk(6);

    frame(1'b0, 3'd3, 9'h155, 16);
    frame(1'b1, 3'd3, 9'h000, 16);
    frame(1'b0, 3'd5, 9'h0AA, 12);
    frame(1'b0, 3'd6, 9'h1FF, 18);
    frame(1'b1, 3'd0, 9'h000, 16);

    // sclk activity with sload high must be ignored
    for (int i = 0; i < 6; i++) begin
      sclk_in = 1'b1; wclk(5);
      sclk_in = 1'b0; wclk(5);
    end
    chk("idle_sclk_regs", regs_o, model_flat());

    // reset in the middle of a read after bit 10
    frame(1'b0, 3'd2, 9'h1A5, 16);
    tb_abort = 1'b1;
    sload_in = 1'b0;
    wclk(4);
    begin
      logic [15:0] w;
      w = {1'b1, 3'd2, 3'd0, 9'h0};
      for (int i = 0; i < 10; i++) begin
        sdata_in = w[15-i];
        wclk(5); sclk_in = 1'b1;
        wclk(5); sclk_in = 1'b0;
      end
    end
    wclk(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", sdata_oe, 1'b0);
    model_reset();
    chk("midrst_regs", regs_o, model_flat());
    wclk(3);
    sload_in = 1'b1;
    wclk(3);
    rst_n = 1'b1;
    wclk(8);
    tb_abort = 1'b0;
    frame(1'b0, 3'd1, 9'h0F3, 16);
    frame(1'b1, 3'd1, 9'h000, 16);

    for (int k = 0; k < 30; k++) begin
      int n;
      n = 16;
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 20);
      end
      frame(1'($urandom), 3'($urandom), 9'($urandom), n);
      if ($urandom_range(0, 2) == 0) wclk($urandom_range(1, 9));
    end

    wclk(20);
    chk("events_drained", ev_q.size(), 0);
    chk("reads_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
